baud_gen_os: RTL and testbench
==============================

Name: baud_gen_os

Overview:
Parametrised successor to the fixed 2-bit-select baud generator. It produces an oversampled receive-sample tick (RxTick) and a bit-rate tick (BaudOut) from one system clock. A fractional divider keeps the average rate exact; the divisor comes from four elaboration-time presets or a runtime custom value. It is shared by UART-Tx (BaudOut) and UART-Rx (RxTick, SampleIdx, ReSync on start-bit detect).

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
OVERSAMPLE, 16, RxTicks per bit; power of two, >= 2
DIV_W, 16, integer-divisor width
FRAC_W, 4, fractional-divisor width

Ports:
Clock  in  1  system clock, all logic on rising edge
ResetN  in  1  synchronous active-low reset
Enable  in  1  generator run enable
ReSync  in  1  single-cycle phase restart request
BaudRate  in  2  preset select: 00=2400, 01=4800, 10=9600, 11=19200 baud
UseCustom  in  1  1 = use CustomDiv instead of the preset
CustomDiv  in  DIV_W+FRAC_W  custom divisor {integer I, fraction F}, in clocks per RxTick
RxTick  out  1  one-cycle pulse at OVERSAMPLE x baud
BaudOut  out  1  one-cycle pulse once per bit, coincident with an RxTick
SampleIdx  out  log2(OVERSAMPLE)  oversample phase within the current bit

Behaviour:
- Preset divisor D = floor(CLK_FREQ*2^FRAC_W/(baud*OVERSAMPLE)), computed at elaboration. I is the upper DIV_W bits of D; F is the lower FRAC_W bits.
- Defaults at 50 MHz/16x/FRAC_W=4: 2400 gives I=1302, F=1; 4800 gives I=651, F=0; 9600 gives I=325, F=8; 19200 gives I=162, F=12.
- Custom: any custom I < 2 is clamped to I=2 (minimum period of 2 clocks). F is used as given.
- State: down-counter cnt[DIV_W-1:0], fraction accumulator acc[FRAC_W-1:0], SampleIdx, and latched active divisor {Ia, Fa}.
- Priority, evaluated each Clock edge: ResetN=0, then Enable=0, then ReSync=1, then run.
- Reset (ResetN=0): RxTick=0, BaudOut=0, SampleIdx=0, acc=0. {Ia, Fa} is loaded from the current selection and cnt=Ia-1.
- Enable=0: same as reset except the registers are not cleared by ResetN. Outputs are 0 and the state is frozen to the reload values, so re-enabling always starts a clean phase.
- ReSync=1 with Enable=1: reload as in reset and issue no tick in that cycle. Used by Rx to align phase to the start-bit edge.
- Run: when cnt != 0, decrement cnt; RxTick=0.
- Run: when cnt == 0:
  - Assert RxTick for one cycle (registered).
  - Compute {c, acc} <= acc + Fa. Re-latch {Ia, Fa} from the inputs. Load cnt <= Ia_new - 1 + c.
  - Increment SampleIdx modulo OVERSAMPLE.
  - BaudOut=1 in the same cycle as the RxTick on which SampleIdx wraps from OVERSAMPLE-1 to 0.
- Period rule: consecutive RxTicks are I or I+1 clocks apart. Over 2^FRAC_W RxTicks, exactly F periods are I+1 clocks.
- The first RxTick after reset release, Enable rise, or ReSync comes exactly I clocks after the first cycle in run state. That period uses no carry.
- BaudOut is asserted on every OVERSAMPLE-th RxTick. The first BaudOut comes on the OVERSAMPLE-th RxTick after a restart.
- Rate changes: BaudRate, UseCustom and CustomDiv are sampled only at reload points (cnt==0, reset, disable, ReSync). A change mid-period never shortens or truncates the current period. acc is not cleared on a rate change.
- No pulse is ever longer than 1 cycle. RxTick and BaudOut are never asserted while Enable=0 or ResetN=0.
- Reset mid-period: all outputs are 0 on the next edge and the full reload of the reset state applies.

Test Plan:
- Reset, then Enable=1, BaudRate=11, UseCustom=0 -> first RxTick 162 clocks after run starts. Over 16 RxTicks, 12 intervals are 163 clocks and 4 are 162 (2604 clocks total). BaudOut on the 16th RxTick with SampleIdx 15 -> 0.
- BaudRate=10 for 32 bits -> BaudOut interval average 5208 clocks; each interval is 5200..5216. RxTick count is exactly 16x the BaudOut count.
- Switch BaudRate 10 -> 00 mid-period -> current period completes at the old length; next period is 1302 clocks. Sweep 11, 10, 01, 00 and check every RxTick spacing is I or I+1.
- UseCustom=1, CustomDiv={I=1, F=0} -> clamped: RxTick every 2 clocks. CustomDiv={I=10, F=0} -> RxTick every 10 clocks, BaudOut every 160 clocks.
- ReSync pulse at SampleIdx=7, mid-count -> no tick that cycle; SampleIdx=0; next RxTick exactly I clocks later; BaudOut 16 RxTicks later.
- Drop Enable, or drive ResetN=0 for one cycle mid-period -> RxTick and BaudOut stay 0 and SampleIdx=0. After restore, timing is identical to a fresh start (first RxTick I clocks later).

Source files
------------

// File: rtl/baud_gen_os_if.sv
// Control and tick bundle between the oversampling baud generator and its
// UART users; master drives rate/phase controls, slave returns the ticks.
interface baud_gen_os_if #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
);
  localparam int IDX_W = $clog2(OVERSAMPLE);

  logic                    Enable;
  logic                    ReSync;
  logic [1:0]              BaudRate;
  logic                    UseCustom;
  logic [DIV_W+FRAC_W-1:0] CustomDiv;
  logic                    RxTick;
  logic                    BaudOut;
  logic [IDX_W-1:0]        SampleIdx;

  modport master (
    output Enable, ReSync, BaudRate, UseCustom, CustomDiv,
    input  RxTick, BaudOut, SampleIdx
  );

  modport slave (
    input  Enable, ReSync, BaudRate, UseCustom, CustomDiv,
    output RxTick, BaudOut, SampleIdx
  );
endinterface

// File: rtl/baud_gen_os.sv
// Oversampling baud generator: fractional divider producing RxTick at
// OVERSAMPLE x baud and BaudOut once per bit, with restart on ReSync/Enable.
module baud_gen_os #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input logic          Clock,
  input logic          ResetN,
  baud_gen_os_if.slave bus
);
  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam int DW    = DIV_W + FRAC_W;

  typedef logic [DW-1:0] div_t;

  // Clocks per RxTick in fixed point with FRAC_W fraction bits, truncated.
  function automatic div_t preset_div(input longint baud);
    longint scaled;
    scaled = (longint'(CLK_FREQ) << FRAC_W) / (baud * longint'(OVERSAMPLE));
    return div_t'(scaled);
  endfunction

  localparam div_t DIV_2400  = preset_div(2400);
  localparam div_t DIV_4800  = preset_div(4800);
  localparam div_t DIV_9600  = preset_div(9600);
  localparam div_t DIV_19200 = preset_div(19200);

  div_t             sel_div;
  logic [DIV_W-1:0] sel_i;
  logic [FRAC_W-1:0] sel_f;
  logic [DIV_W-1:0] reload_cnt;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    sel_div = DIV_2400;
    if (bus.UseCustom) begin
      sel_div = bus.CustomDiv;
    end else begin
      case (bus.BaudRate)
        2'b00:   sel_div = DIV_2400;
        2'b01:   sel_div = DIV_4800;
        2'b10:   sel_div = DIV_9600;
        default: sel_div = DIV_19200;
      endcase
    end
    sel_i = sel_div[DW-1:FRAC_W];
    sel_f = sel_div[FRAC_W-1:0];
    // A period shorter than two clocks would merge adjacent ticks.
    if (sel_i < DIV_W'(2)) sel_i = DIV_W'(2);
  end

  assign reload_cnt = sel_i - DIV_W'(1);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] fa_q, fa_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rx_tick_q, rx_tick_d;
  logic              baud_out_q, baud_out_d;
  logic [FRAC_W:0]   acc_sum;

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    fa_d       = fa_q;
    idx_d      = idx_q;
    rx_tick_d  = 1'b0;
    baud_out_d = 1'b0;
    acc_sum    = {1'b0, acc_q} + {1'b0, fa_q};

    if (!bus.Enable || bus.ReSync) begin
      cnt_d = reload_cnt;
      acc_d = '0;
      fa_d  = sel_f;
      idx_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end else begin
      // Carry out of the accumulator stretches the next period by one clock.
      rx_tick_d  = 1'b1;
      baud_out_d = (idx_q == IDX_W'(OVERSAMPLE - 1));
      acc_d      = acc_sum[FRAC_W-1:0];
      fa_d       = sel_f;
      cnt_d      = reload_cnt + DIV_W'(acc_sum[FRAC_W]);
      idx_d      = idx_q + IDX_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      cnt_q      <= reload_cnt;
      acc_q      <= '0;
      fa_q       <= sel_f;
      idx_q      <= '0;
      rx_tick_q  <= 1'b0;
      baud_out_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      fa_q       <= fa_d;
      idx_q      <= idx_d;
      rx_tick_q  <= rx_tick_d;
      baud_out_q <= baud_out_d;
    end
  end

  assign bus.RxTick    = rx_tick_q;
  assign bus.BaudOut   = baud_out_q;
  assign bus.SampleIdx = idx_q;

endmodule

// File: tb/tb_baud_gen_os.sv
// Directed bench for baud_gen_os: preset timing, fractional spacing, rate
// changes, custom clamp, ReSync, Enable drop and mid-period reset.
module tb_baud_gen_os;
  localparam int TICK_BUDGET = 1500;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  int          sweep_i   [4] = '{162, 325, 651, 1302};
  logic [1:0]  sweep_sel [4] = '{2'b11, 2'b10, 2'b01, 2'b00};

  always #5 clk = ~clk;

  baud_gen_os_if bus ();

  baud_gen_os dut (
    .Clock  (clk),
    .ResetN (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Counts clocks (negedge samples) until the next RxTick, bounded.
  task automatic wait_tick(input string tag, output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    while (!got && n < TICK_BUDGET) begin
      @(negedge clk);
      n++;
      if (bus.RxTick === 1'b1) got = 1'b1;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s: observed=no RxTick expected=RxTick within %0d clocks", tag, TICK_BUDGET);
    end
  endtask

  // One disabled cycle: outputs must be quiet and phase cleared, then re-enable.
  task automatic restart(input string tag);
    bus.Enable = 1'b0;
    @(negedge clk);
    check({tag, "_rxtick"}, bus.RxTick, 0);
    check({tag, "_baudout"}, bus.BaudOut, 0);
    check({tag, "_idx"}, bus.SampleIdx, 0);
    bus.Enable = 1'b1;
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: observed=timeout expected=bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, sum, n163, bo_tick, idx15, idx16;
    int ticks, first_bo, bouts, since, bmin, bmax, bsum, prev_i, bad;

    rst_n         = 1'b0;
    bus.Enable    = 1'b1;
    bus.ReSync    = 1'b0;
    bus.BaudRate  = 2'b11;
    bus.UseCustom = 1'b0;
    bus.CustomDiv = '0;
    idx15 = -1;
    idx16 = -1;

    // Reset state, then 19200 baud: I=162, F=12.
    repeat (3) @(negedge clk);
    check("reset_rxtick", bus.RxTick, 0);
    check("reset_baudout", bus.BaudOut, 0);
    check("reset_idx", bus.SampleIdx, 0);
    rst_n = 1'b1;
    wait_tick("t1_first", n);
    check("t1_first_interval", n, 162);
    check("t1_first_idx", bus.SampleIdx, 1);
    check("t1_first_baudout", bus.BaudOut, 0);
    sum = 0; n163 = 0; bo_tick = 0;
    for (int k = 2; k <= 17; k++) begin
      wait_tick("t1_run", n);
      sum += n;
      if (n == 163) n163++;
      if (bus.BaudOut === 1'b1 && bo_tick == 0) bo_tick = k;
      if (k == 15) idx15 = int'(bus.SampleIdx);
      if (k == 16) idx16 = int'(bus.SampleIdx);
    end
    check("t1_sum_16_periods", sum, 2604);
    check("t1_long_periods", n163, 12);
    check("t1_baudout_tick", bo_tick, 16);
    check("t1_idx_tick15", idx15, 15);
    check("t1_idx_tick16", idx16, 0);

    // 9600 baud: every bit is exactly 5208 clocks, 16 RxTicks per bit.
    bus.BaudRate = 2'b10;
    restart("t2_restart");
    ticks = 0; bouts = 0; since = 0; first_bo = 0;
    bmin = 1 << 30; bmax = 0; bsum = 0;
    while (bouts < 5 && ticks < 200) begin
      wait_tick("t2_run", n);
      ticks++;
      since += n;
      if (bus.BaudOut === 1'b1) begin
        bouts++;
        if (bouts == 1) first_bo = ticks;
        else begin
          bsum += since;
          if (since < bmin) bmin = since;
          if (since > bmax) bmax = since;
        end
        since = 0;
      end
    end
    check("t2_baudouts", bouts, 5);
    check("t2_first_baud_tick", first_bo, 16);
    check("t2_ticks_per_4_bits", ticks - first_bo, 64);
    check_range("t2_bit_min", bmin, 5200, 5216);
    check_range("t2_bit_max", bmax, 5200, 5216);
    check("t2_bit_sum", bsum, 4 * 5208);

    // Mid-period switch to 2400: old period (carry set) completes, then 1302.
    repeat (100) @(negedge clk);
    bus.BaudRate = 2'b00;
    wait_tick("t3_old", n);
    check("t3_old_period", n + 100, 326);
    wait_tick("t3_new", n);
    check("t3_new_period", n, 1302);

    // Rate sweep: first period after a change keeps the old rate.
    prev_i = 1302;
    for (int r = 0; r < 4; r++) begin
      bus.BaudRate = sweep_sel[r];
      wait_tick("sweep_old", n);
      check_range("sweep_old_period", n, prev_i, prev_i + 1);
      for (int j = 0; j < 3; j++) begin
        wait_tick("sweep_new", n);
        check_range("sweep_new_period", n, sweep_i[r], sweep_i[r] + 1);
      end
      prev_i = sweep_i[r];
    end

    // Custom divisor below the minimum is clamped to 2 clocks.
    bus.UseCustom = 1'b1;
    bus.CustomDiv = {16'd1, 4'd0};
    restart("t4_clamp_restart");
    for (int j = 0; j < 4; j++) begin
      wait_tick("t4_clamp", n);
      check("t4_clamp_period", n, 2);
    end
    bus.CustomDiv = {16'd10, 4'd0};
    restart("t4_div10_restart");
    bouts = 0; ticks = 0; since = 0;
    while (bouts < 2 && ticks < 64) begin
      wait_tick("t4_div10", n);
      ticks++;
      since += n;
      if (ticks == 1) check("t4_div10_first", n, 10);
      if (bus.BaudOut === 1'b1) begin
        bouts++;
        check(bouts == 1 ? "t4_first_baud" : "t4_baud_interval", since, 160);
        since = 0;
      end
    end
    check("t4_baud_count", bouts, 2);

    // ReSync mid-count at SampleIdx 7.
    bus.UseCustom = 1'b0;
    bus.BaudRate  = 2'b11;
    restart("t5_restart");
    for (int j = 0; j < 7; j++) wait_tick("t5_pre", n);
    check("t5_idx_before", bus.SampleIdx, 7);
    repeat (50) @(negedge clk);
    bus.ReSync = 1'b1;
    @(negedge clk);
    bus.ReSync = 1'b0;
    check("t5_resync_rxtick", bus.RxTick, 0);
    check("t5_resync_idx", bus.SampleIdx, 0);
    wait_tick("t5_first", n);
    check("t5_first_interval", n, 162);
    ticks = 1;
    while (bus.BaudOut !== 1'b1 && ticks < 40) begin
      wait_tick("t5_run", n);
      ticks++;
    end
    check("t5_baud_tick", ticks, 16);

    // Enable held low well past a tick boundary: fully quiet and frozen.
    for (int j = 0; j < 3; j++) wait_tick("t6_pre", n);
    repeat (40) @(negedge clk);
    bus.Enable = 1'b0;
    bad = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (bus.RxTick !== 1'b0 || bus.BaudOut !== 1'b0 || bus.SampleIdx !== '0) bad++;
    end
    check("t6_disabled_quiet", bad, 0);
    bus.Enable = 1'b1;
    wait_tick("t6_reenable", n);
    check("t6_reenable_first", n, 162);

    // One-cycle reset mid-period.
    for (int j = 0; j < 2; j++) wait_tick("t7_pre", n);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_reset_rxtick", bus.RxTick, 0);
    check("t7_reset_baudout", bus.BaudOut, 0);
    check("t7_reset_idx", bus.SampleIdx, 0);
    rst_n = 1'b1;
    wait_tick("t7_first", n);
    check("t7_first_interval", n, 162);
    check("t7_first_idx", bus.SampleIdx, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
